// File: rtl/sdram_rr_arbiter_pkg.sv
// Shared constants for the SDRAM round-robin arbiter.
// Master indices follow the m_* bus packing order.
package sdram_arb_pkg;

  localparam int NUM_M = 4;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [1:0] M_CPU   = 2'd0;
  localparam logic [1:0] M_FIR   = 2'd1;
  localparam logic [1:0] M_QSORT = 2'd2;
  localparam logic [1:0] M_MM    = 2'd3;

endpackage

// File: rtl/sdram_rr_arbiter_if.sv
// Wishbone bundle between the DMA masters, the arbiter
// and the SDRAM-controller adapter.
interface sdram_rr_arbiter_if;
  import sdram_arb_pkg::*;

  logic [NUM_M-1:0]    m_cyc;
  logic [NUM_M-1:0]    m_stb;
  logic [NUM_M-1:0]    m_we;
  logic [4*NUM_M-1:0]  m_sel;
  logic [32*NUM_M-1:0] m_dat_i;
  logic [32*NUM_M-1:0] m_adr;
  logic [NUM_M-1:0]    m_ack;
  logic [31:0]         m_dat_o;

  logic        s_cyc;
  logic        s_stb;
  logic        s_we;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_o;
  logic [31:0] s_adr;
  logic        s_ack;
  logic [31:0] s_dat_i;

  modport slave (
    input  m_cyc, m_stb, m_we, m_sel, m_dat_i, m_adr,
    output m_ack, m_dat_o,
    output s_cyc, s_stb, s_we, s_sel, s_dat_o, s_adr,
    input  s_ack, s_dat_i
  );

  modport master (
    output m_cyc, m_stb, m_we, m_sel, m_dat_i, m_adr,
    input  m_ack, m_dat_o,
    input  s_cyc, s_stb, s_we, s_sel, s_dat_o, s_adr,
    output s_ack, s_dat_i
  );

endinterface

// File: rtl/sdram_rr_arbiter_rr_select.sv
// Combinational 4-way round-robin picker.
// The search starts just after the last owner.
module rr_select (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] gnt_idx,
  output logic       any
);

  logic [1:0] idx;

  // Walk from the farthest slot back so the nearest wins.
  always_comb begin
    idx     = '0;
    gnt_idx = last;
    any     = |req;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (req[idx]) gnt_idx = idx;
    end
  end

endmodule

// File: rtl/sdram_rr_arbiter.sv
// Round-robin Wishbone arbiter sharing one SDRAM port
// among four DMA masters, with a per-grant beat limit.
module sdram_rr_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int NUM_M     = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic             clk,
  input  logic             rst,
  sdram_rr_arbiter_if.slave bus,
  output logic [NUM_M-1:0] grant,
  output logic             busy
);

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BEATS - 1);
  localparam bit         LIMITED   = (MAX_BEATS != 0);

  state_e           state_q, state_d;
  logic [NUM_M-1:0] grant_q, grant_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       beat_q, beat_d;

  logic [1:0] pick;
  logic       any;
  logic       others;
  logic       preempt;

  rr_select u_rr_select (
    .req     (bus.m_cyc),
    .last    (last_q),
    .gnt_idx (pick),
    .any     (any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    beat_d  = beat_q;
    others  = |(bus.m_cyc & ~grant_q);
    preempt = 1'b0;
    case (state_q)
      ST_IDLE: begin
        beat_d = '0;
        if (any) begin
          state_d       = ST_BUSY;
          owner_d       = pick;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
        end
      end
      ST_BUSY: begin
        preempt = LIMITED && bus.s_ack &&
                  (beat_q == LAST_BEAT) && others;
        if (!bus.m_cyc[owner_q] || preempt) begin
          state_d = ST_IDLE;
          grant_d = '0;
          last_d  = owner_q;
          beat_d  = '0;
        end else if (bus.s_ack &&
                     (!LIMITED || beat_q != LAST_BEAT)) begin
          beat_d = beat_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      owner_q <= M_CPU;
      last_q  <= M_MM;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  assign busy  = (state_q == ST_BUSY);
  assign grant = grant_q;

  assign bus.s_cyc   = busy & bus.m_cyc[owner_q];
  assign bus.s_stb   = busy & bus.m_stb[owner_q];
  assign bus.s_we    = busy & bus.m_we[owner_q];
  assign bus.s_sel   = bus.m_sel[{owner_q, 2'b00} +: 4];
  assign bus.s_dat_o = bus.m_dat_i[{owner_q, 5'b0} +: 32];
  assign bus.s_adr   = bus.m_adr[{owner_q, 5'b0} +: 32];

  assign bus.m_ack   = {NUM_M{bus.s_ack}} & grant_q;
  assign bus.m_dat_o = bus.s_dat_i;

endmodule

// File: doc/sdram_rr_arbiter.md
# sdram_rr_arbiter

- Round-robin Wishbone arbiter that shares the single SDRAM controller port among four DMA masters: CPU-side DMA, FIR, QSORT and MM.
- Replaces fixed-priority arbitration so that no master starves.
- Adds a per-grant beat limit, so one master cannot hold the SDRAM indefinitely while others are waiting.
- Sits between the DMA engines and the SDRAM-controller Wishbone adapter.

## Interface
Parameters:
- NUM_M, 4: number of masters; this block supports exactly 4.
- MAX_BEATS, 16: acks per grant before forced release if another master is requesting; legal range 0..255; 0 = unlimited.

Ports:
- clk, in, 1: clock.
- rst, in, 1: synchronous, active-high reset.
- m_cyc, in, 4: per-master cycle; bit 0 = CPU, 1 = FIR, 2 = QSORT, 3 = MM.
- m_stb, in, 4: per-master strobe.
- m_we, in, 4: per-master write enable.
- m_sel, in, 16: per-master byte enables; master i at [4i+3:4i].
- m_dat_i, in, 128: per-master write data; master i at [32i+31:32i].
- m_adr, in, 128: per-master address; same packing as m_dat_i.
- m_ack, out, 4: per-master ack.
- m_dat_o, out, 32: read data, broadcast to all masters.
- s_cyc, s_stb, s_we, out, 1 each: to SDRAM adapter.
- s_sel, out, 4: to SDRAM adapter.
- s_dat_o, s_adr, out, 32 each: to SDRAM adapter.
- s_ack, in, 1: from SDRAM adapter.
- s_dat_i, in, 32: from SDRAM adapter.
- grant, out, 4: one-hot owner, registered.
- busy, out, 1: state == BUSY.

## Operation
- Request: master i is requesting when m_cyc[i] = 1. m_stb is not considered.
- States:
  - IDLE: grant = 0; s_cyc = s_stb = 0.
  - BUSY: the owner's cyc, stb, we, sel, dat and adr are muxed to the s_* outputs.
- IDLE → BUSY when any request is present.
  - Winner = first requesting index searched from (last+1) mod 4, wrapping.
  - grant, owner and state load at the next edge.
- BUSY → IDLE on either condition:
  - (a) the owner's m_cyc = 0;
  - (b) MAX_BEATS ≠ 0, s_ack = 1, beat_cnt == MAX_BEATS−1, and any other master is requesting.
- On leaving BUSY: last ← owner; beat_cnt ← 0.
- BUSY always returns through at least one IDLE cycle; there is no back-to-back grant.
- beat_cnt: 8 bits; increments on each s_ack in BUSY; cleared in IDLE.
  - With no competing requester it saturates at MAX_BEATS−1 and the owner keeps the grant.
- m_ack[i] = s_ack & grant[i]. An s_ack seen in IDLE is ignored.
- m_dat_o = s_dat_i, unconditionally.
- A preempted owner keeps cyc asserted and re-enters arbitration in IDLE. It now has the lowest priority because last = that owner.
- Owner drops cyc in the same cycle as its final ack: the ack is delivered and the arbiter releases. Condition (a) applies.
- Reset values: state IDLE, grant 0, busy 0, last 3 (so master 0 wins the first arbitration), beat_cnt 0, s_cyc/s_stb 0, m_ack 0.

## Timing
- Grant latency: request first seen at edge t → grant and s_cyc valid after edge t+1. One cycle in IDLE.
- s_* outputs are combinational from the registered grant and the owner's inputs.
- Ack path s_ack → m_ack is combinational, zero latency.
- Handover: owner cyc low at edge t → IDLE during t+1 → next owner on s_* after t+2.
- Reset mid-transaction:
  - grant is dropped at the next edge;
  - the SDRAM adapter is reset by the same rst, so no stale ack is forwarded.

## Structure
- Shared package sdram_arb_pkg holds:
  - NUM_M;
  - state encodings ST_IDLE = 1'b0, ST_BUSY = 1'b1;
  - master index constants M_CPU = 0, M_FIR = 1, M_QSORT = 2, M_MM = 3.
- One sub-module, rr_select: combinational 4-way round-robin picker.
  - Inputs: req[3:0], last[1:0].
  - Outputs: gnt_idx[1:0], any.
- The top level holds the FSM, beat counter and output muxes.

## Test plan
- Reset, then m_cyc = 4'b1111 held with single-beat accesses → owner order 0, 1, 2, 3, 0, with exactly one IDLE cycle between grants.
- Only FIR requests (m_cyc = 4'b0010), 40 read beats, MAX_BEATS = 16 → grant is never dropped; 40 m_ack[1] pulses; beat_cnt stops at 15.
- FIR bursting and MM raises cyc during FIR beat 5, MAX_BEATS = 16 → FIR is released after its 16th ack and MM is granted 2 cycles later. FIR regains the grant once MM finishes.
- Stray s_ack while in IDLE → m_ack stays 4'b0000.
- CPU write 0xDEADBEEF to address 0x100 with sel 0xF while QSORT is idle → s_adr = 0x100, s_dat_o = 0xDEADBEEF, s_we = 1, and the ack is routed only to m_ack[0].
- rst asserted during an MM burst → next cycle: grant = 0, s_cyc = 0, last = 3. The first request after reset goes to the lowest-index requester.
